// File: rtl/spi_master_if.sv
// SPI master bus bundle: request/response handshake plus the four SPI pins.
// Latency: none (wiring only).
// Backpressure: none; start_i is only honoured while busy_o is low.
interface spi_master_if #(
    parameter int IO_COUNT = 16
);
    logic                start_i;
    logic [IO_COUNT-1:0] data_i;
    logic [IO_COUNT-1:0] data_o;
    logic                done_o;
    logic                busy_o;
    logic                nss_o;
    logic                sck_o;
    logic                sdo_o;
    logic                sdi_i;

    // Seen from the SPI master block.
    modport master (
        input  start_i,
        input  data_i,
        input  sdi_i,
        output data_o,
        output done_o,
        output busy_o,
        output nss_o,
        output sck_o,
        output sdo_o
    );

    // Seen from the user of the master and the attached SPI slave.
    modport slave (
        output start_i,
        output data_i,
        output sdi_i,
        input  data_o,
        input  done_o,
        input  busy_o,
        input  nss_o,
        input  sck_o,
        input  sdo_o
    );
endinterface

// File: rtl/spi_master.sv
// SPI master: one full-duplex IO_COUNT-bit transfer per accepted start, MSB first.
// Latency: done_o (2*IO_COUNT+1)*DIV cycles after accept; busy_o drops DIV cycles later.
// Backpressure: start_i is accepted only while busy_o=0; starts during a transfer are dropped.
module spi_master #(
    parameter int IO_COUNT = 16,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0,
    parameter int DIV      = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    spi_master_if.master bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int EW = $clog2(2 * IO_COUNT + 1);

    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);
    localparam logic [EW-1:0] LAST_EDGE  = EW'(2 * IO_COUNT);
    // The one non-sampling edge that must not advance the TX register:
    // the final trailing edge in CPHA=0, the first leading edge in CPHA=1.
    localparam logic [EW-1:0] NO_SHIFT_EDGE = CPHA ? EW'(1) : LAST_EDGE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [IO_COUNT-1:0] tx_q, tx_d;
    logic [IO_COUNT-1:0] rx_q, rx_d;
    logic [IO_COUNT-1:0] data_q, data_d;
    logic                nss_q, nss_d;
    logic                sck_q, sck_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tick;
    logic [EW-1:0]       edge_k;
    logic                sample_edge;

    // Phase timer expiry and the index of the SCK edge it would produce.
    assign tick        = (cnt_q == '0);
    assign edge_k      = edge_q + 1'b1;
    assign sample_edge = edge_k[0] ^ CPHA;

    // Next-state, shift-register and pin logic for the transfer sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        data_d  = data_q;
        nss_d   = nss_q;
        sck_d   = sck_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_SETUP;
                    cnt_d   = CNT_RELOAD;
                    edge_d  = '0;
                    tx_d    = bus.data_i;
                    rx_d    = '0;
                    nss_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            // SETUP expiry produces edge 1, so both states share the edge logic.
            S_SETUP, S_SHIFT: begin
                if (tick) begin
                    cnt_d  = CNT_RELOAD;
                    edge_d = edge_k;
                    sck_d  = ~sck_q;
                    if (sample_edge) begin
                        rx_d = {rx_q[IO_COUNT-2:0], bus.sdi_i};
                    end else if (edge_k != NO_SHIFT_EDGE) begin
                        tx_d = {tx_q[IO_COUNT-2:0], 1'b0};
                    end
                    state_d = (edge_k == LAST_EDGE) ? S_HOLD : S_SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_HOLD: begin
                if (tick) begin
                    cnt_d   = CNT_RELOAD;
                    nss_d   = 1'b1;
                    data_d  = rx_q;
                    done_d  = 1'b1;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // Keeps busy high so NSS stays deasserted for at least DIV cycles.
            S_GAP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transfer without a completion strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            nss_q   <= 1'b1;
            sck_q   <= CPOL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            nss_q   <= nss_d;
            sck_q   <= sck_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.data_o = data_q;
    assign bus.done_o = done_q;
    assign bus.busy_o = busy_q;
    assign bus.nss_o  = nss_q;
    assign bus.sck_o  = sck_q;
    // MOSI is forced low whenever the slave is not selected.
    assign bus.sdo_o  = tx_q[IO_COUNT-1] & ~nss_q;
endmodule

// File: doc/spi_master.md
# spi_master

SPI bus master that runs one full-duplex, fixed-length transfer per request. It is the counterpart of the FPGA's `spi_slave`. Instances drive an external SPI slave, or the FPGA's own slave in loopback test builds. It shares the `IO_COUNT`/`CPOL`/`CPHA` mode parameters with `spi_slave` and generates SCK by dividing the system clock.

## Interface
- `IO_COUNT`, 16: bits per transfer (≥2), MSB first.
- `CPOL`, 0: SCK idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- `DIV`, 2: SCK half-period in `clk_i` cycles (≥1).
- `clk_i`  in  1: system clock. One clock domain; everything is registered on the rising edge.
- `rst_i`  in  1: synchronous, active-high reset.
- `start_i`  in  1: transfer request. Accepted only when `busy_o`=0.
- `data_i`  in  IO_COUNT: transmit word, captured on the accept edge.
- `data_o`  out  IO_COUNT: last received word, held until the next completion.
- `done_o`  out  1: one-cycle completion strobe.
- `busy_o`  out  1: transfer in progress.
- `nss_o`  out  1: slave select, active low.
- `sck_o`  out  1: serial clock.
- `sdo_o`  out  1: MOSI.
- `sdi_i`  in  1: MISO. Sampled directly at SCK edge clocks.

## Operation
- FSM states: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE. A single down-counter of width clog2(DIV) times every phase; an edge counter of width clog2(2·IO_COUNT+1) tracks SCK edges.
- IDLE:
  - `nss_o`=1, `sck_o`=CPOL, `sdo_o`=0.
  - `start_i`=1 loads `data_i` into the TX shift register and clears the RX shift register.
- SETUP (DIV cycles): `nss_o`=0, `sdo_o`=TX MSB.
- SHIFT: `sck_o` toggles every DIV cycles, giving 2·IO_COUNT edges k=1..2·IO_COUNT. Odd k are leading edges; even k are trailing edges.
  - CPHA=0: sample `sdi_i` into the RX LSB on odd k. Shift TX left on even k, except k=2·IO_COUNT.
  - CPHA=1: shift TX on odd k≥3. Sample `sdi_i` on even k.
- HOLD (DIV cycles after the last edge): `sck_o`=CPOL, `nss_o`=0.
- End of HOLD: `nss_o`→1, `sdo_o`→0, `data_o`←RX register, `done_o`=1 for one cycle.
- GAP (DIV cycles): `busy_o` stays 1 and guarantees a minimum NSS-high time.
- `start_i` while `busy_o`=1 is ignored; it is not queued.

## Timing
- Reset values: `nss_o`=1, `sck_o`=CPOL, `sdo_o`=0, `busy_o`=0, `done_o`=0, `data_o`=0. State is IDLE.
- `rst_i` during any state aborts the transfer at the next edge with the values above. No `done_o` is produced and `data_o` keeps its reset value of 0.
- Let N=IO_COUNT and let start be accepted at edge T.
  - `busy_o`=1, `nss_o`=0 and `sdo_o`=`data_i`[N-1] at T+1.
  - SCK edge k at T+1+k·DIV.
  - `nss_o` rises, `done_o`=1 and `data_o` updates at T+1+(2N+1)·DIV.
  - `busy_o`=0 at T+1+(2N+2)·DIV.
- A start asserted in the first cycle with `busy_o`=0 is accepted. Back-to-back transfers have a period of (2N+2)·DIV+1 cycles.
- `done_o` never coincides with `busy_o`=0.
- DIV=1: SCK = clk_i/2, and all phase lengths scale identically.

## Test plan
- Reset:
  - Hold `rst_i` 3 cycles with `start_i`=1 → all outputs at reset values.
  - Release → the start is accepted on the first non-reset edge.
- Loopback, mode 0, DIV=2, `sdo_o`→`sdi_i`, `data_i`=0xA5C3 at edge T:
  - `nss_o` low at T+1; 32 SCK edges at T+3…T+65.
  - `done_o` at T+67 with `data_o`=0xA5C3; `busy_o`=0 at T+69.
- Modes 1/2/3 against a behavioural SPI slave model returning 0x3C5A while expecting 0x8001:
  - `data_o`=0x3C5A, the model captures 0x8001, and the SCK idle level equals CPOL.
- Busy handling, DIV=2, N=16:
  - Pulse `start_i` with `data_i`=0xFFFF at T+10 during a 0x1234 transfer → ignored, exactly one `done_o`, slave receives 0x1234.
  - `start_i` held high → new transfers begin every 69 cycles.
- Abort: assert `rst_i` at edge k=9 → `nss_o`=1 and `sck_o`=CPOL next cycle, no `done_o`, `data_o`=0.
- DIV=1, N=2, `data_i`=2'b10, `sdi_i` tied 1 → `done_o` at T+6, `busy_o` low at T+7, `data_o`=2'b11.
